pc_sequencer: RTL and testbench



---
 rtl/mips_defs.sv | 33 +++
 rtl/npc_calc.sv | 73 +++++++
 rtl/pc_sequencer.sv | 130 +++++++++++++
 tb/tb_pc_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
`default_nettype none
// ============================================================================
//  Module      : mips_defs (package)
//  Description : Shared encodings for the mips32 fetch sequencer: FSM states,
//                next-PC redirect select, default reset/trap addresses and
//                the branch displacement helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_defs;

    localparam logic [31:0] c_RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [31:0] c_EXC_VECTOR_DEF = 32'h0000_0080;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_JR     = 2'd3
    } npc_sel_e;

    // Signed word offset turned into a signed byte displacement.
    function automatic logic [31:0] branch_disp(input logic [15:0] off);
        return {{14{off[15]}}, off, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/npc_calc.sv
`default_nettype none
// ============================================================================
//  Module      : npc_calc
//  Description : Combinational next-PC selection. Priority jr > jump >
//                branch > sequential. Optional macro MISALIGN_TRAP_EN turns a
//                misaligned jr target into a trap to EXC_VECTOR.
//  Revision    : 1.0 - initial release
// ============================================================================
module npc_calc
    import mips_defs::*;
#(
    parameter logic [31:0] EXC_VECTOR = c_EXC_VECTOR_DEF
) (
    input  logic [31:0] pc_plus4_i,
    input  logic        branch_taken_i,
    input  logic [15:0] branch_off_i,
    input  logic        jump_i,
    input  logic [25:0] jump_target_i,
    input  logic        jr_i,
    input  logic [31:0] jr_addr_i,
    output logic [31:0] npc_o,
    output logic        misalign_o
);

    npc_sel_e w_sel;

    // Pick the redirect source by fixed priority.
    always_comb begin
        w_sel = SEL_SEQ;
        if (jr_i)                w_sel = SEL_JR;
        else if (jump_i)         w_sel = SEL_JUMP;
        else if (branch_taken_i) w_sel = SEL_BRANCH;
    end

`ifdef MISALIGN_TRAP_EN
    // Form the next PC; a misaligned jr target diverts to the trap vector.
    always_comb begin
        npc_o      = pc_plus4_i;
        misalign_o = 1'b0;
        case (w_sel)
            SEL_BRANCH: npc_o = pc_plus4_i + branch_disp(branch_off_i);
            SEL_JUMP:   npc_o = {pc_plus4_i[31:28], jump_target_i, 2'b00};
            SEL_JR: begin
                if (jr_addr_i[1:0] != 2'b00) begin
                    npc_o      = EXC_VECTOR;
                    misalign_o = 1'b1;
                end else begin
                    npc_o = jr_addr_i;
                end
            end
            default:    npc_o = pc_plus4_i;
        endcase
    end
`else
    // Low jr bits are dropped, so the trap vector is never needed here.
    logic w_unused;
    assign w_unused = &{1'b0, jr_addr_i[1:0], EXC_VECTOR};

    // Form the next PC; jr targets are forced word aligned.
    always_comb begin
        npc_o      = pc_plus4_i;
        misalign_o = 1'b0;
        case (w_sel)
            SEL_BRANCH: npc_o = pc_plus4_i + branch_disp(branch_off_i);
            SEL_JUMP:   npc_o = {pc_plus4_i[31:28], jump_target_i, 2'b00};
            SEL_JR:     npc_o = {jr_addr_i[31:2], 2'b00};
            default:    npc_o = pc_plus4_i;
        endcase
    end
`endif

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Instruction fetch sequencer. Owns the PC, runs the imem
//                req/ack handshake and holds the fetched word for decode.
//                IDLE -> FETCH -> ISSUE -> FETCH ... Optional macro
//                MISALIGN_TRAP_EN enables the misaligned-jr trap/addr_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC   = c_RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = c_EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [15:0] branch_off,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic        addr_err
);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        instr_valid_q;
    logic        imem_req_q;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_npc;
    logic        w_misalign;
    logic        w_advance;

    assign w_pc_plus4 = pc_q + 32'd4;
    assign w_advance  = (state_q == ISSUE) && !stall;

    npc_calc #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_npc_calc (
        .pc_plus4_i     (w_pc_plus4),
        .branch_taken_i (branch_taken),
        .branch_off_i   (branch_off),
        .jump_i         (jump),
        .jump_target_i  (jump_target),
        .jr_i           (jr),
        .jr_addr_i      (jr_addr),
        .npc_o          (w_npc),
        .misalign_o     (w_misalign)
    );

    // Fetch FSM: request is raised on entry to FETCH, dropped on ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q    <= FETCH;
                    imem_req_q <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr_q       <= imem_rdata;
                        instr_valid_q <= 1'b1;
                        imem_req_q    <= 1'b0;
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        pc_q          <= w_npc;
                        instr_valid_q <= 1'b0;
                        imem_req_q    <= 1'b1;
                        state_q       <= FETCH;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    instr_valid_q <= 1'b0;
                    imem_req_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic addr_err_q;

    // One-cycle error pulse when a misaligned jr is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= w_advance && w_misalign;
        end
    end

    assign addr_err = addr_err_q;
`else
    logic w_unused;
    assign w_unused = &{1'b0, w_misalign, w_advance};
    assign addr_err = 1'b0;
`endif

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = w_pc_plus4;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer. Expected fetch
//                addresses and instruction words are queued by the stimulus;
//                a monitor pops and compares them on each handshake / new
//                instruction. Honours MISALIGN_TRAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch_taken;
    logic [15:0] branch_off;
    logic        jump;
    logic [25:0] jump_target;
    logic        jr;
    logic [31:0] jr_addr;
    logic        addr_err;

`ifdef MISALIGN_TRAP_EN
    localparam logic [31:0] c_EXP_MIS = 32'h0000_0080;
    localparam logic [31:0] c_EXP_ERR = 32'd1;
`else
    localparam logic [31:0] c_EXP_MIS = 32'h0000_1000;
    localparam logic [31:0] c_EXP_ERR = 32'd0;
`endif

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .jump         (jump),
        .jump_target  (jump_target),
        .jr           (jr),
        .jr_addr      (jr_addr),
        .addr_err     (addr_err)
    );

    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] last_data;
    logic        prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare each handshake address and each newly presented instruction.
    always @(negedge clk) begin
        if (imem_req === 1'b1 && imem_ack === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                n_total++;
                $display("FAIL fetch_unexpected: got addr %h expected no fetch", imem_addr);
            end else begin
                chk("fetch_addr", imem_addr, exp_addr_q.pop_front());
            end
        end
        if (instr_valid === 1'b1 && prev_valid !== 1'b1) begin
            if (exp_instr_q.size() == 0) begin
                n_total++;
                $display("FAIL instr_unexpected: got %h expected no instruction", instr);
            end else begin
                chk("instr", instr, exp_instr_q.pop_front());
            end
        end
        prev_valid = instr_valid;
    end

    // Wait for a request, hold off ack for 'waits' cycles, then complete it.
    task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] data, input int waits);
        int guard = 0;
        while (imem_req !== 1'b1 && guard < 10) begin
            step();
            guard++;
        end
        chk("req_seen", {31'd0, imem_req}, 32'd1);
        for (int i = 0; i < waits; i++) begin
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, exp_addr);
            step();
        end
        exp_addr_q.push_back(exp_addr);
        exp_instr_q.push_back(data);
        last_data  = data;
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'hA5A5_5A5A;
        chk("req_drop", {31'd0, imem_req}, 32'd0);
    endtask

    // Release the current instruction with the given redirect inputs.
    task automatic issue(input logic br, input logic [15:0] off, input logic jmp,
                         input logic [25:0] tgt, input logic jrr, input logic [31:0] ja,
                         input logic [31:0] exp_pc);
        chk("issue_valid", {31'd0, instr_valid}, 32'd1);
        branch_taken = br;
        branch_off   = off;
        jump         = jmp;
        jump_target  = tgt;
        jr           = jrr;
        jr_addr      = ja;
        step();
        branch_taken = 1'b0;
        jump         = 1'b0;
        jr           = 1'b0;
        chk("next_pc", pc, exp_pc);
        chk("valid_clear", {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; stall = 1'b0;
        branch_taken = 1'b0; branch_off = 16'd0; jump = 1'b0; jump_target = 26'd0;
        jr = 1'b0; jr_addr = 32'd0; last_data = 32'd0;
        step();
        step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_err", {31'd0, addr_err}, 32'd0);
        reset = 1'b0;

        // Sequential stream with same-cycle ack.
        fetch_one(32'h0, 32'h2000_0001, 0);
        issue(0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h4);
        fetch_one(32'h4, 32'h2000_0002, 0);
        issue(0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h8);
        fetch_one(32'h8, 32'h2000_0003, 0);

        // Jump within the 256 MB region.
        issue(0, 16'h0, 0, 26'h0, 1, 32'h0040_0010, 32'h0040_0010);
        fetch_one(32'h0040_0010, 32'h2000_0004, 0);
        issue(0, 16'h0, 1, 26'h010_0000, 0, 32'h0, 32'h0040_0000);
        fetch_one(32'h0040_0000, 32'h2000_0005, 0);

        // Backward branch, then branch+jump where jump wins.
        issue(0, 16'h0, 0, 26'h0, 1, 32'h0000_0100, 32'h100);
        fetch_one(32'h100, 32'h2000_0006, 0);
        issue(1, 16'hFFFE, 0, 26'h0, 0, 32'h0, 32'hFC);
        fetch_one(32'hFC, 32'h2000_0007, 0);
        issue(1, 16'hFFFE, 1, 26'h000_0100, 0, 32'h0, 32'h400);
        fetch_one(32'h400, 32'h2000_0008, 0);

        // Stall for three cycles with branch_taken toggling.
        for (int i = 0; i < 3; i++) begin
            stall        = 1'b1;
            branch_taken = (i % 2 == 0);
            branch_off   = 16'h0010;
            step();
            chk("stall_pc", pc, 32'h400);
            chk("stall_instr", instr, last_data);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        stall = 1'b0;
        issue(1, 16'h0010, 0, 26'h0, 0, 32'h0, 32'h444);

        // Four memory wait states.
        fetch_one(32'h444, 32'h2000_0009, 4);

        // Wrap forwards past the top, then branch below zero.
        issue(0, 16'h0, 0, 26'h0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        fetch_one(32'hFFFF_FFFC, 32'h2000_000A, 0);
        issue(0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h0);
        fetch_one(32'h0, 32'h2000_000B, 0);
        issue(1, 16'hFFFE, 0, 26'h0, 0, 32'h0, 32'hFFFF_FFFC);
        fetch_one(32'hFFFF_FFFC, 32'h2000_000C, 0);

        // Misaligned register jump.
        issue(0, 16'h0, 0, 26'h0, 1, 32'h0000_1002, c_EXP_MIS);
        chk("addr_err_pulse", {31'd0, addr_err}, c_EXP_ERR);
        step();
        chk("addr_err_clear", {31'd0, addr_err}, 32'd0);
        fetch_one(c_EXP_MIS, 32'h2000_000D, 0);
        issue(0, 16'h0, 0, 26'h0, 0, 32'h0, c_EXP_MIS + 32'd4);

        // Reset while waiting for ack, then a late ack in IDLE.
        step();
        chk("abort_req", {31'd0, imem_req}, 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_pc", pc, 32'h0);
        chk("abort_valid", {31'd0, instr_valid}, 32'd0);
        chk("abort_req_low", {31'd0, imem_req}, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack   = 1'b0;
        chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
        chk("late_ack_instr", instr, 32'h0);
        chk("late_ack_req", {31'd0, imem_req}, 32'd1);
        fetch_one(32'h0, 32'h2000_000E, 0);
        step();

        chk("addr_queue_drained", exp_addr_q.size(), 32'd0);
        chk("instr_queue_drained", exp_instr_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
